// File: rtl/dds_pkg.sv
// Shared definitions for the DDS PWM generator: waveform select codes,
// the counter-limit helper and the quarter-wave sine table generator.
package dds_pkg;

   localparam logic [1:0] WAVE_SQUARE = 2'b00;
   localparam logic [1:0] WAVE_SINE   = 2'b01;
   localparam logic [1:0] WAVE_SAW    = 2'b10;
   localparam logic [1:0] WAVE_TRI    = 2'b11;

   // All-ones value of a width-bit counter
   function automatic int unsigned max_count(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   // Offset-binary quarter-wave entry: centre + round(peak * sin(pi/2 * idx/n)),
   // where n = 2^aw - 1 so idx 0 is the centre and idx n is the peak.
   // Sine uses the integer Bhaskara approximation so it folds to constants.
   function automatic int unsigned sine_quarter(input int unsigned idx,
                                                input int unsigned aw,
                                                input int unsigned dw);
      longint unsigned n, a, b, span, pk, num, den, mag;
      n    = (64'd1 << aw) - 64'd1;
      a    = 64'(idx);
      span = 64'd2 * n;
      b    = span - a;
      pk   = (64'd1 << (dw - 1)) - 64'd1;
      num  = 64'd16 * pk * a * b;
      den  = 64'd5 * span * span - 64'd4 * a * b;
      mag  = (num + den / 64'd2) / den;
      return 32'((64'd1 << (dw - 1)) + mag);
   endfunction

endpackage

// File: rtl/dds_pwm_generator_sine_lut.sv
// Combinational sine source: quarter-wave table with quadrant mirroring
// and reflection about the centre code for the negative half-cycle.
module dds_sine_lut
   import dds_pkg::*;
#(
   parameter int unsigned DAC_W  = 8,
   parameter int unsigned LUT_AW = 6
) (
   input  logic [LUT_AW+1:0] phase_top,
   output logic [DAC_W-1:0]  sine_c
);

   localparam int unsigned DEPTH = 32'd1 << LUT_AW;

   logic [DAC_W-1:0]  qtab [DEPTH];
   logic [LUT_AW-1:0] idx;
   logic [DAC_W-1:0]  qval;

   // Constant quarter-wave table
   for (genvar i = 0; i < DEPTH; i++) begin : g_tab
      assign qtab[i] = DAC_W'(sine_quarter(32'(i), LUT_AW, DAC_W));
   end

   // Mirror the index in odd quadrants, reflect about centre in the negative half
   always_comb begin
      idx    = phase_top[LUT_AW] ? ~phase_top[LUT_AW-1:0] : phase_top[LUT_AW-1:0];
      qval   = qtab[idx];
      sine_c = phase_top[LUT_AW+1] ? DAC_W'(~qval + DAC_W'(1)) : qval;
   end

endmodule

// File: rtl/dds_pwm_generator.sv
// DDS function generator driving a single PWM pin.
// Phase accumulator + waveform shaping + amplitude scaling feed a PWM whose
// duty is updated only at period boundaries; config changes go through a
// shadow/pending handshake so they also apply only at boundaries.
// Optional feature macro: PHASE_CLR_EN (adds phase_clr strobe input).
module dds_pwm_generator
   import dds_pkg::*;
#(
   parameter int unsigned PHASE_W = 16,
   parameter int unsigned DAC_W   = 8,
   parameter int unsigned LUT_AW  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               cfg_load,
   input  logic [1:0]         wave_sel,
   input  logic [PHASE_W-1:0] ftw,
   input  logic [DAC_W-1:0]   amp,
`ifdef PHASE_CLR_EN
   input  logic               phase_clr,
`endif
   output logic               cfg_ack,
   output logic               period_start,
   output logic [DAC_W-1:0]   sample,
   output logic               pwm
);

   localparam int unsigned      PROD_W  = 2 * DAC_W + 1;
   localparam logic [DAC_W-1:0] CNT_MAX = DAC_W'(max_count(DAC_W));

   logic [DAC_W-1:0]   pwm_cnt;
   logic [PHASE_W-1:0] phase;
   logic [DAC_W-1:0]   sample_q;
   logic [DAC_W-1:0]   duty_q;
   logic [1:0]         wave_act, wave_sh;
   logic [PHASE_W-1:0] ftw_act, ftw_sh;
   logic [DAC_W-1:0]   amp_act, amp_sh;
   logic               pending;

   logic               boundary_c;
   logic [PHASE_W-1:0] phase_nxt_c;
   logic [DAC_W-1:0]   p_c, tri_c, sine_c, raw_c, scaled_c;
   logic [PROD_W-1:0]  prod_c;

   assign boundary_c = en & (pwm_cnt == CNT_MAX);
   assign p_c        = phase[PHASE_W-1 -: DAC_W];
   assign tri_c      = {p_c[DAC_W-2:0], 1'b0};
   assign sample     = duty_q;

`ifdef PHASE_CLR_EN
   logic clr_req;

   // Hold a phase-clear request until the next enabled boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clr_req <= 1'b0;
      else        clr_req <= phase_clr | (clr_req & ~boundary_c);
   end

   assign phase_nxt_c = clr_req ? '0 : phase + ftw_act;
`else
   assign phase_nxt_c = phase + ftw_act;
`endif

   dds_sine_lut #(
      .DAC_W  (DAC_W),
      .LUT_AW (LUT_AW)
   ) u_sine (
      .phase_top (phase[PHASE_W-1 -: LUT_AW+2]),
      .sine_c    (sine_c)
   );

   // Waveform selection from the current phase
   always_comb begin
      raw_c = '0;
      unique case (wave_act)
         WAVE_SQUARE: raw_c = phase[PHASE_W-1] ? '1 : '0;
         WAVE_SINE:   raw_c = sine_c;
         WAVE_SAW:    raw_c = p_c;
         default:     raw_c = phase[PHASE_W-1] ? ~tri_c : tri_c;
      endcase
   end

   // Amplitude scaling with gain (amp+1)/2^DAC_W on the full-width product
   always_comb begin
      prod_c   = PROD_W'(raw_c) * (PROD_W'(amp_act) + PROD_W'(1));
      scaled_c = DAC_W'(prod_c >> DAC_W);
   end

   // PWM counter and phase accumulator, both frozen while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         phase   <= '0;
      end else begin
         if (en)         pwm_cnt <= pwm_cnt + DAC_W'(1);
         if (boundary_c) phase   <= phase_nxt_c;
      end
   end

   // Sample pipeline, duty latch at boundary and registered PWM/period outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q     <= '0;
         duty_q       <= '0;
         pwm          <= 1'b0;
         period_start <= 1'b0;
      end else begin
         sample_q     <= scaled_c;
         if (boundary_c) duty_q <= sample_q;
         pwm          <= en & (pwm_cnt < duty_q);
         period_start <= boundary_c;
      end
   end

   // Shadow capture and pending flag; a load on a boundary waits for the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_sh <= WAVE_SQUARE;
         ftw_sh  <= '0;
         amp_sh  <= '0;
         pending <= 1'b0;
      end else if (cfg_load) begin
         wave_sh <= wave_sel;
         ftw_sh  <= ftw;
         amp_sh  <= amp;
         pending <= 1'b1;
      end else if (boundary_c) begin
         pending <= 1'b0;
      end
   end

   // Promote pending config to active at a boundary and acknowledge it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_act <= WAVE_SQUARE;
         ftw_act  <= '0;
         amp_act  <= '0;
         cfg_ack  <= 1'b0;
      end else begin
         cfg_ack <= boundary_c & pending;
         if (boundary_c && pending) begin
            wave_act <= wave_sh;
            ftw_act  <= ftw_sh;
            amp_act  <= amp_sh;
         end
      end
   end

endmodule

// File: tb/tb_dds_pwm_generator.sv
// Self-checking bench for dds_pwm_generator: period-level reference model,
// directed scenarios plus randomized config/enable traffic.
module tb_dds_pwm_generator;

   localparam int unsigned PHASE_W = 16;
   localparam int unsigned DAC_W   = 8;
   localparam int unsigned LUT_AW  = 6;
   localparam int          PERIOD  = 256;

   logic               clk = 1'b0;
   logic               rst_n, en, cfg_load;
   logic [1:0]         wave_sel;
   logic [PHASE_W-1:0] ftw;
   logic [DAC_W-1:0]   amp;
   logic               cfg_ack, period_start, pwm;
   logic [DAC_W-1:0]   sample;
`ifdef PHASE_CLR_EN
   logic               phase_clr = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int          m_cnt, m_wave, m_amp, m_duty, m_acc, m_pend, sh_wave, sh_amp;
   logic [15:0] m_phase, m_ftw, sh_ftw;
   bit          tol;
   int          acks, starts, pwm_hi, smin, smax;

   always #5 clk = ~clk;

   dds_pwm_generator #(
      .PHASE_W (PHASE_W),
      .DAC_W   (DAC_W),
      .LUT_AW  (LUT_AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cfg_load     (cfg_load),
      .wave_sel     (wave_sel),
      .ftw          (ftw),
      .amp          (amp),
`ifdef PHASE_CLR_EN
      .phase_clr    (phase_clr),
`endif
      .cfg_ack      (cfg_ack),
      .period_start (period_start),
      .sample       (sample),
      .pwm          (pwm)
   );

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scaled waveform value for a phase/config, straight from the waveform definitions
   function automatic int ref_sample(input int ph, input int wave, input int a);
      int  p, raw, q, idx, i, m;
      real mag;
      p = ph / 256;
      case (wave)
         0: raw = (ph >= 32768) ? 255 : 0;
         2: raw = p;
         3: raw = (p < 128) ? 2 * p : 511 - 2 * p;
         default: begin
            q   = (ph / 16384) % 2;
            idx = (ph / 256) % 64;
            i   = (q != 0) ? 63 - idx : idx;
            mag = 127.0 * $sin(3.14159265358979 / 2.0 * real'(i) / 63.0);
            m   = $rtoi(mag + 0.5);
            raw = (ph >= 32768) ? 128 - m : 128 + m;
         end
      endcase
      return (raw * (a + 1)) / 256;
   endfunction

   // One clock: advance, then compare outputs against the model and update it
   task automatic cycle();
      bit bnd;
      bnd = (en === 1'b1) && (m_cnt == 255);
      @(posedge clk);
      #1;
      if (en) begin
         if (m_cnt == 0) m_acc = 0;
         m_acc += int'(pwm);
         if (m_cnt == 255) begin
            if (tol) check("pwm_high_tol", (m_acc - m_duty <= 1) && (m_duty - m_acc <= 1), 1);
            else     check("pwm_high", m_acc, m_duty);
         end
      end else begin
         check("pwm_off", pwm, 0);
      end
      check("period_start", period_start, bnd);
      check("cfg_ack", cfg_ack, bnd && (m_pend != 0));
      if (bnd) begin
         m_duty  = ref_sample(int'(m_phase), m_wave, m_amp);
         m_phase = m_phase + m_ftw;
         if (m_pend != 0) begin
            m_wave = sh_wave;
            m_ftw  = sh_ftw;
            m_amp  = sh_amp;
         end
      end
      if (tol) check("sample_tol", (int'(sample) - m_duty <= 1) && (m_duty - int'(sample) <= 1), 1);
      else     check("sample", sample, m_duty);
      if (cfg_load) begin
         sh_wave = int'(wave_sel);
         sh_ftw  = ftw;
         sh_amp  = int'(amp);
         m_pend  = 1;
      end else if (bnd) begin
         m_pend = 0;
      end
      if (en) m_cnt = (m_cnt + 1) % 256;
      acks   += int'(cfg_ack);
      starts += int'(period_start);
      pwm_hi += int'(pwm);
      if (int'(sample) < smin) smin = int'(sample);
      if (int'(sample) > smax) smax = int'(sample);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic run_to(input int c);
      for (int k = 0; k < 600 && m_cnt != c; k++) cycle();
   endtask

   task automatic load(input int w, input int f, input int a);
      wave_sel = 2'(w);
      ftw      = 16'(f);
      amp      = 8'(a);
      cfg_load = 1'b1;
      cycle();
      cfg_load = 1'b0;
   endtask

   // Assert reset asynchronously, hold it with random inputs, clear the model
   task automatic reset_phase(input int ncyc);
      rst_n = 1'b0;
      #1;
      check("rst_async_pwm", pwm, 0);
      check("rst_async_sample", sample, 0);
      for (int k = 0; k < ncyc; k++) begin
         en       = 1'b1;
         cfg_load = 1'($urandom_range(0, 1));
         wave_sel = 2'($urandom);
         ftw      = 16'($urandom);
         amp      = 8'($urandom);
         @(posedge clk);
         #1;
         check("rst_pwm", pwm, 0);
         check("rst_sample", sample, 0);
         check("rst_ack", cfg_ack, 0);
         check("rst_period_start", period_start, 0);
      end
      m_cnt = 0; m_phase = '0; m_wave = 0; m_ftw = '0; m_amp = 0;
      m_pend = 0; m_duty = 0; m_acc = 0;
      sh_wave = 0; sh_ftw = '0; sh_amp = 0;
      cfg_load = 1'b0;
      en       = 1'b1;
      rst_n    = 1'b1;
   endtask

   initial begin
      int s1, s2, sa, sb, n, w;
      rst_n = 1'b1; en = 1'b0; cfg_load = 1'b0;
      wave_sel = '0; ftw = '0; amp = '0; tol = 1'b0;
      acks = 0; starts = 0; pwm_hi = 0; smin = 999; smax = -1;
      #2;

      // reset and idle: amp 0 keeps the output low
      reset_phase(6);
      pwm_hi = 0;
      run(3 * PERIOD);
      check("idle_pwm_hi", pwm_hi, 0);

      // sine quarter points from phase 0
      run_to(50);
      load(1, 'h4000, 255);
      run_to(0);
      run(PERIOD);
      smin = 999; smax = -1;
      run(4 * PERIOD);
      check("sine_peak", smax, 255);
      check("sine_trough", smin, 1);

      // saw ramp
      run_to(30);
      acks = 0;
      load(2, 'h1000, 255);
      run(18 * PERIOD);
      check("saw_ack_once", acks, 1);

      // square at half amplitude
      load(0, 'h8000, 127);
      run(3 * PERIOD);
      run_to(1);
      s1 = int'(sample);
      run(PERIOD);
      s2 = int'(sample);
      check("square_pair_sum", s1 + s2, 127);
      check("square_pair_prod", s1 * s2, 0);

      // sine sweep over the whole table, model rounding allowed to differ by 1
      tol = 1'b1;
      load(1, 'h0500, 255);
      run(28 * PERIOD);
      load(2, 'h0200, 255);
      run(3 * PERIOD);
      tol = 1'b0;

      // back-to-back loads in one period: last write wins, single ack
      run_to(10);
      acks = 0;
      load(2, 'h0100, 255);
      run(20);
      load(2, 'h0200, 255);
      run_to(0);
      run(2 * PERIOD);
      check("hs_single_ack", acks, 1);
      sa = int'(sample);
      run(PERIOD);
      sb = int'(sample);
      check("hs_step", (sb - sa) & 255, 2);

      // load exactly on a boundary cycle acks one period later
      run_to(255);
      wave_sel = 2'd3; ftw = 16'h0700; amp = 8'd200; cfg_load = 1'b1;
      cycle();
      cfg_load = 1'b0;
      n = 0;
      while (n < 600) begin
         cycle();
         n++;
         if (cfg_ack) break;
      end
      check("hs_boundary_latency", n, 256);

      // disable mid-period, load while disabled, resume
      run_to(100);
      en = 1'b0;
      acks = 0; starts = 0;
      run(20);
      load(2, 'h0040, 255);
      run(29);
      check("en_off_starts", starts, 0);
      check("en_off_acks", acks, 0);
      en = 1'b1;
      n = 0;
      while (n < 600) begin
         cycle();
         n++;
         if (period_start) break;
      end
      check("en_resume_latency", n, 156);
      check("en_resume_ack", cfg_ack, 1);

      // randomized config and enable traffic
      for (int k = 0; k < 60 * PERIOD; k++) begin
         en       = ($urandom_range(0, 63) != 0);
         cfg_load = ($urandom_range(0, 199) == 0);
         if (cfg_load) begin
            w = $urandom_range(0, 2);
            if (w == 1) w = 3;
            wave_sel = 2'(w);
            ftw      = 16'($urandom);
            amp      = 8'($urandom);
         end
         cycle();
      end
      en = 1'b1;
      cfg_load = 1'b0;

      // reset with a pending config: nothing survives
      load(2, 'h3000, 255);
      run(3 * PERIOD);
      run_to(128);
      load(3, 'h2000, 99);
      run(10);
      reset_phase(3);
      acks = 0;
      run(2 * PERIOD + 10);
      check("rst_no_ack", acks, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dds_pwm_generator.md
Name: dds_pwm_generator

Overview:
- Parametrised direct-digital-synthesis (DDS) function generator that drives a single PWM output pin. Successor to the fixed 8-bit divider/counter/LUT generator.
- A PHASE_W-bit phase accumulator with a programmable frequency tuning word replaces the clock divider.
- Adds a square wave, amplitude scaling, and a glitch-free config-update handshake.
- Sits at the top level between the input pins and uo_out[0].

Parameters:
- PHASE_W, 16: phase accumulator width.
- DAC_W, 8: sample and PWM resolution; PWM period is 2^DAC_W clocks.
- LUT_AW, 6: quarter-wave sine table address bits; LUT_AW <= PHASE_W-2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: run enable.
- cfg_load, in, 1: one-cycle strobe; captures wave_sel, ftw and amp.
- wave_sel, in, 2: 00 square, 01 sine, 10 saw, 11 triangle.
- ftw, in, PHASE_W: frequency tuning word (phase increment per PWM period).
- amp, in, DAC_W: amplitude; effective gain is (amp+1)/2^DAC_W.
- cfg_ack, out, 1: one-cycle pulse when pending config becomes active.
- period_start, out, 1: one-cycle pulse on the first cycle of each PWM period.
- sample, out, DAC_W: currently applied duty value.
- pwm, out, 1: PWM output.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all state cleared. pwm=0, sample=0, cfg_ack=0, period_start=0, phase=0, pwm_cnt=0, pending=0. Active config is wave_sel=00, ftw=0, amp=0.
- pwm_cnt: DAC_W-bit up-counter, advances only when en=1 and wraps MAX->0.
- Boundary cycle: en=1 and pwm_cnt=MAX. On that cycle:
  - duty_q <= sample_q
  - phase <= phase + ftw_act (modulo 2^PHASE_W; wrap is silent)
  - pending config copies to active, and cfg_ack pulses.
- period_start is registered: it is high on the cycle where pwm_cnt=0 following a boundary.
- pwm = en & (pwm_cnt < duty_q), registered, so there is 1 cycle of latency from the counter.
  - duty 0 gives constant low.
  - duty MAX gives high for 2^DAC_W-1 clocks, low for 1.
- Waveform raw value: let p = the top DAC_W bits of phase.
  - Saw: raw = p.
  - Square: all ones if phase MSB=1, else 0.
  - Triangle: raw = {p[DAC_W-2:0],0} when MSB=0; its bitwise inverse when MSB=1.
  - Sine: offset-binary quarter-wave lookup, mirrored by phase[MSB-1] and inverted by phase[MSB]. Table centre is 2^(DAC_W-1); peak is 2^DAC_W-1; trough is 1.
- Scaling: sample_q <= (raw*(amp_act+1)) >> DAC_W.
  - The full 2*DAC_W+1-bit product is kept before the shift.
  - sample_q is registered every cycle, so it has 1 cycle of latency from phase.
- Sample timing: the sample for a given phase is applied at the boundary after that phase is loaded.
- Handshake:
  - cfg_load=1 captures the inputs into shadow registers and sets pending.
  - If cfg_load repeats while pending is set, the last write wins and only one cfg_ack is produced.
  - If cfg_load coincides with a boundary, the new values apply at the following boundary, not this one.
  - ftw, wave_sel and amp never change mid-period.
- en=0:
  - pwm_cnt and phase hold, and pwm is forced 0.
  - cfg_load is still captured.
  - cfg_ack waits for an enabled boundary.
- Reset mid-operation: immediate clear, with no pending config retained.

Optional Feature:
- Macro: PHASE_CLR_EN.
- When defined, adds input port phase_clr (1 bit).
  - A strobe sets a clear-request flag.
  - At the next boundary the phase loads 0 instead of phase+ftw_act.
  - If cfg_load and phase_clr arrive together, both take effect at the same boundary.
- When undefined, the port and flag are absent and the phase only accumulates.

Decomposition:
- Package dds_pkg holds:
  - wave_sel constants WAVE_SQUARE, WAVE_SINE, WAVE_SAW, WAVE_TRI
  - quarter-wave sine table generation function
  - MAX count helper
- Sub-module dds_sine_lut is combinational. It takes phase top bits, returns the DAC_W sine value, and contains the quarter-wave mirroring and inversion logic.
- The accumulator, PWM and handshake logic stay in dds_pwm_generator.

Test Plan:
Defaults apply: PHASE_W=16, DAC_W=8, 256-clock period.
1. Reset: hold rst_n=0 with en=1 and random inputs -> all outputs 0. Release with no cfg_load -> pwm stays 0 indefinitely (amp=0).
2. Saw: cfg_load with wave_sel=10, ftw=0x1000, amp=255 -> cfg_ack at first boundary. Per-period pwm high count is 0,0,16,32,... (16*(k-1)), wrapping after 16 steps. period_start spacing is 256 clocks.
3. Square: wave_sel=00, ftw=0x8000, amp=127 -> sample alternates 127 and 0 each period. Measured high times are 127 and 0.
4. Sine: wave_sel=01, ftw=0x4000, amp=255 -> successive applied samples are 128, 255, 128, 1 (repeating).
5. Handshake: cfg_load ftw=0x0100, then cfg_load ftw=0x0200 in the same period -> exactly one cfg_ack, and phase step is 0x0200. cfg_load exactly on the boundary cycle -> ack one period later.
6. Enable: drop en at pwm_cnt=100 for 50 clocks -> pwm=0 and phase/pwm_cnt frozen. Re-raise en -> resumes from count 100 with no extra boundary or cfg_ack.
